// File: rtl/enemy_lives.sv
// Per-enemy hit-point tracker for five enemies, with a timed re-arm window
// entered on level_up that restores every enemy to a level-dependent HP.
module enemy_lives #(
  parameter int unsigned RESPAWN_DELAY = 1000,
  parameter int unsigned HP_MAX        = 7
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       hit_1,
  input  logic       hit_2,
  input  logic       hit_3,
  input  logic       hit_4,
  input  logic       hit_5,
  input  logic [3:0] level,
  input  logic       level_up,
  output logic       lives_1,
  output logic       lives_2,
  output logic       lives_3,
  output logic       lives_4,
  output logic       lives_5,
  output logic       kill_pulse,
  output logic [2:0] alive_count,
  output logic       respawning
);

  localparam int unsigned N_ENEMY = 5;
  localparam int unsigned HP_W    = 3;
  localparam int unsigned LVL_W   = 4;
  localparam int unsigned CNT_W   = (RESPAWN_DELAY > 1) ? $clog2(RESPAWN_DELAY) : 1;
  localparam int unsigned ALIVE_W = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_DELAY - 1);

  typedef enum logic {
    ST_ACTIVE       = 1'b0,
    ST_RESPAWN_WAIT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [HP_W-1:0]      hp_q [N_ENEMY];
  logic [HP_W-1:0]      hp_d [N_ENEMY];
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [N_ENEMY-1:0]   lives_q, lives_d;
  logic                 kill_q, kill_d;
  logic [ALIVE_W-1:0]   alive_q, alive_d;
  logic                 resp_q, resp_d;

  logic [N_ENEMY-1:0]   hit_vec_c;
  logic [HP_W-1:0]      rearm_hp_c;

  assign hit_vec_c = {hit_5, hit_4, hit_3, hit_2, hit_1};

  // Re-arm HP from the captured level: level 0 still gets one hit point.
  always_comb begin
    rearm_hp_c = HP_W'(1);
    if (level_q == '0) begin
      rearm_hp_c = HP_W'(1);
    end else if (level_q > LVL_W'(HP_MAX)) begin
      rearm_hp_c = HP_W'(HP_MAX);
    end else begin
      rearm_hp_c = HP_W'(level_q);
    end
  end

  // Next-state logic; level_up wins over hits and restarts the wait window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    kill_d  = 1'b0;
    for (int i = 0; i < N_ENEMY; i++) begin
      hp_d[i] = hp_q[i];
    end

    case (state_q)
      ST_ACTIVE: begin
        if (level_up) begin
          state_d = ST_RESPAWN_WAIT;
          level_d = level;
          cnt_d   = '0;
        end else begin
          for (int i = 0; i < N_ENEMY; i++) begin
            if (hit_vec_c[i] && (hp_q[i] != '0)) begin
              hp_d[i] = hp_q[i] - HP_W'(1);
              if (hp_q[i] == HP_W'(1)) begin
                kill_d = 1'b1;
              end
            end
          end
        end
      end

      ST_RESPAWN_WAIT: begin
        if (level_up) begin
          level_d = level;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          for (int i = 0; i < N_ENEMY; i++) begin
            hp_d[i] = rearm_hp_c;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_ACTIVE;
      end
    endcase
  end

  // Registered status derived from next-state so outputs track HP with no lag.
  always_comb begin
    alive_d = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      lives_d[i] = (hp_d[i] != '0);
      alive_d    = alive_d + ALIVE_W'(lives_d[i]);
    end
    resp_d = (state_d == ST_RESPAWN_WAIT);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= ST_ACTIVE;
      cnt_q   <= '0;
      level_q <= LVL_W'(1);
      lives_q <= '1;
      kill_q  <= 1'b0;
      alive_q <= ALIVE_W'(N_ENEMY);
      resp_q  <= 1'b0;
      for (int i = 0; i < N_ENEMY; i++) begin
        hp_q[i] <= HP_W'(1);
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      lives_q <= lives_d;
      kill_q  <= kill_d;
      alive_q <= alive_d;
      resp_q  <= resp_d;
      for (int i = 0; i < N_ENEMY; i++) begin
        hp_q[i] <= hp_d[i];
      end
    end
  end

  assign lives_1     = lives_q[0];
  assign lives_2     = lives_q[1];
  assign lives_3     = lives_q[2];
  assign lives_4     = lives_q[3];
  assign lives_5     = lives_q[4];
  assign kill_pulse  = kill_q;
  assign alive_count = alive_q;
  assign respawning  = resp_q;

endmodule

// File: tb/tb_enemy_lives.sv
// Directed and randomized checks of enemy_lives against a countdown-based
// behavioural model of enemy HP, kills and the respawn window.
module tb_enemy_lives;

  localparam int unsigned DELAY = 4;
  localparam int unsigned HPM   = 7;

  logic       pclk = 1'b0;
  logic       rst;
  logic       hit_1, hit_2, hit_3, hit_4, hit_5;
  logic [3:0] level;
  logic       level_up;
  logic       lives_1, lives_2, lives_3, lives_4, lives_5;
  logic       kill_pulse;
  logic [2:0] alive_count;
  logic       respawning;

  int checks = 0;
  int errors = 0;

  // Reference model state: hit points, waiting flag, cycles of waiting left.
  int m_hp [5];
  bit m_wait;
  int m_left;
  int m_cap;
  bit m_kill;

  always #5 pclk = ~pclk;

  enemy_lives #(
    .RESPAWN_DELAY(DELAY),
    .HP_MAX       (HPM)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .hit_1      (hit_1),
    .hit_2      (hit_2),
    .hit_3      (hit_3),
    .hit_4      (hit_4),
    .hit_5      (hit_5),
    .level      (level),
    .level_up   (level_up),
    .lives_1    (lives_1),
    .lives_2    (lives_2),
    .lives_3    (lives_3),
    .lives_4    (lives_4),
    .lives_5    (lives_5),
    .kill_pulse (kill_pulse),
    .alive_count(alive_count),
    .respawning (respawning)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [4:0] h, input int lv, input bit lu, input bit r);
    m_kill = 1'b0;
    if (r) begin
      foreach (m_hp[i]) m_hp[i] = 1;
      m_wait = 1'b0;
      m_left = 0;
      m_cap  = 1;
    end else if (!m_wait) begin
      if (lu) begin
        m_wait = 1'b1;
        m_left = DELAY;
        m_cap  = lv;
      end else begin
        foreach (m_hp[i]) begin
          if (h[i] && m_hp[i] > 0) begin
            m_hp[i] = m_hp[i] - 1;
            if (m_hp[i] == 0) m_kill = 1'b1;
          end
        end
      end
    end else begin
      if (lu) begin
        m_cap  = lv;
        m_left = DELAY;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_wait = 1'b0;
          foreach (m_hp[i]) m_hp[i] = (m_cap == 0) ? 1 : (m_cap > int'(HPM) ? int'(HPM) : m_cap);
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs.
  task automatic step(input logic [4:0] h, input logic [3:0] lv, input bit lu, input bit r);
    logic [4:0] exp_lives;
    int exp_alive;
    {hit_5, hit_4, hit_3, hit_2, hit_1} = h;
    level    = lv;
    level_up = lu;
    rst      = r;
    @(posedge pclk);
    model(h, int'(lv), lu, r);
    #1;
    exp_alive = 0;
    foreach (m_hp[i]) begin
      exp_lives[i] = (m_hp[i] != 0);
      exp_alive   += (m_hp[i] != 0) ? 1 : 0;
    end
    chk("lives", 32'({lives_5, lives_4, lives_3, lives_2, lives_1}), 32'(exp_lives));
    chk("kill_pulse", 32'(kill_pulse), 32'(m_kill));
    chk("alive_count", 32'(alive_count), 32'(exp_alive));
    chk("respawning", 32'(respawning), 32'(m_wait));
    {hit_5, hit_4, hit_3, hit_2, hit_1} = '0;
    level_up = 1'b0;
    rst      = 1'b0;
  endtask

  initial begin
    {hit_5, hit_4, hit_3, hit_2, hit_1} = '0;
    level    = '0;
    level_up = 1'b0;
    rst      = 1'b1;
    m_wait   = 1'b0;
    m_left   = 0;
    m_cap    = 1;
    m_kill   = 1'b0;
    foreach (m_hp[i]) m_hp[i] = 1;

    // Reset state
    step(5'b00000, 4'd0, 1'b0, 1'b1);
    step(5'b00000, 4'd0, 1'b0, 1'b1);
    step(5'b00000, 4'd0, 1'b0, 1'b0);

    // Single kill of enemy 3, pulse lasts one cycle
    step(5'b00100, 4'd0, 1'b0, 1'b0);
    step(5'b00000, 4'd0, 1'b0, 1'b0);
    step(5'b00100, 4'd0, 1'b0, 1'b0);

    // All enemies hit at once, then hits on dead enemies
    step(5'b11111, 4'd0, 1'b0, 1'b0);
    step(5'b11111, 4'd0, 1'b0, 1'b0);
    step(5'b00000, 4'd0, 1'b0, 1'b0);
    repeat (3) step(5'b00000, 4'd0, 1'b0, 1'b0);

    // Respawn at level 3, then three hits on enemy 2
    step(5'b00000, 4'd3, 1'b1, 1'b0);
    repeat (DELAY) step(5'b00010, 4'd0, 1'b0, 1'b0);
    repeat (3) begin
      step(5'b00010, 4'd0, 1'b0, 1'b0);
      step(5'b00000, 4'd0, 1'b0, 1'b0);
    end

    // level_up and hit_4 together: hit discarded
    step(5'b01000, 4'd5, 1'b1, 1'b0);
    repeat (DELAY) step(5'b01000, 4'd0, 1'b0, 1'b0);

    // Level above HP_MAX clips to 7 hits
    step(5'b00000, 4'd12, 1'b1, 1'b0);
    repeat (DELAY) step(5'b00000, 4'd0, 1'b0, 1'b0);
    repeat (8) step(5'b11111, 4'd0, 1'b0, 1'b0);

    // level_up inside the window restarts it; level 0 re-arms to 1 HP
    step(5'b00000, 4'd9, 1'b1, 1'b0);
    step(5'b00000, 4'd0, 1'b0, 1'b0);
    step(5'b00000, 4'd0, 1'b1, 1'b0);
    repeat (DELAY + 1) step(5'b00000, 4'd0, 1'b0, 1'b0);
    step(5'b10101, 4'd0, 1'b0, 1'b0);

    // Reset in the middle of the respawn window
    step(5'b00000, 4'd6, 1'b1, 1'b0);
    step(5'b00000, 4'd0, 1'b0, 1'b0);
    step(5'b00000, 4'd0, 1'b0, 1'b1);
    step(5'b00000, 4'd0, 1'b0, 1'b0);

    // Randomized traffic
    repeat (600) begin
      logic [4:0] h;
      logic [3:0] lv;
      bit lu, r;
      h  = 5'($urandom) & 5'($urandom);
      lv = 4'($urandom_range(0, 15));
      lu = ($urandom_range(0, 14) == 0);
      r  = ($urandom_range(0, 99) == 0);
      step(h, lv, lu, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
